// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared SAP-1 opcodes, control-word bit positions, control words and T-state type
// Contents:
//   OP_*        4-bit opcode constants (IR[7:4])
//   CW_*        bit positions inside the 12-bit control word, MSB = Cp
//   CW_WORD_*   complete control words for fetch, execute and idle cycles
//   t_state_e   one-hot ring-counter state; all-zero encodes the halted state
package sap_pkg;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   // Bit positions, {Cp, Ep, Lm_n, Ce_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n}
   localparam int CW_CP   = 11;
   localparam int CW_EP   = 10;
   localparam int CW_LM_N = 9;
   localparam int CW_CE_N = 8;
   localparam int CW_LI_N = 7;
   localparam int CW_EI_N = 6;
   localparam int CW_LA_N = 5;
   localparam int CW_EA   = 4;
   localparam int CW_SU   = 3;
   localparam int CW_EU   = 2;
   localparam int CW_LB_N = 1;
   localparam int CW_LO_N = 0;

   localparam logic [11:0] CW_WORD_FETCH_T1 = 12'h5E3;  // Ep, Lm
   localparam logic [11:0] CW_WORD_FETCH_T2 = 12'hBE3;  // Cp
   localparam logic [11:0] CW_WORD_FETCH_T3 = 12'h263;  // Ce, Li
   localparam logic [11:0] CW_WORD_ADDR_T4  = 12'h1A3;  // Ei, Lm  (LDA/ADD/SUB)
   localparam logic [11:0] CW_WORD_LDA_T5   = 12'h2C3;  // Ce, La
   localparam logic [11:0] CW_WORD_ARITH_T5 = 12'h2E1;  // Ce, Lb  (ADD/SUB)
   localparam logic [11:0] CW_WORD_ADD_T6   = 12'h3C7;  // Eu, La
   localparam logic [11:0] CW_WORD_SUB_T6   = 12'h3CF;  // Su, Eu, La
   localparam logic [11:0] CW_WORD_OUT_T4   = 12'h3F2;  // Ea, Lo
   localparam logic [11:0] CW_WORD_NOP      = 12'h3E3;  // nothing enabled, nothing loaded

   typedef enum logic [5:0] {
      T_HALT = 6'b000000,
      T1     = 6'b000001,
      T2     = 6'b000010,
      T3     = 6'b000100,
      T4     = 6'b001000,
      T5     = 6'b010000,
      T6     = 6'b100000
   } t_state_e;

endpackage

// File: rtl/sap_control_datapath_if.sv
// rtl/sap_control_datapath_if.sv - signal bundle between the SAP controller/datapath block and its surroundings
// Signals:
//   instruction  opcode IR[7:4]            control_word  12-bit control word
//   pc           program counter (4 bit)   w_bus         W-bus value
//   ram          RAM data word             alu_result    adder/subtractor output
//   ir           IR operand IR[3:0]        t_state       one-hot ring state
//   acc, b       A and B registers         halted        HLT reached
// Modports: master drives the register/opcode inputs, slave is the controller block.
interface sap_control_datapath_if;

   logic [3:0]  instruction;
   logic [3:0]  pc;
   logic [7:0]  ram;
   logic [3:0]  ir;
   logic [7:0]  acc;
   logic [7:0]  b;
   logic [11:0] control_word;
   logic [7:0]  w_bus;
   logic [7:0]  alu_result;
   logic [5:0]  t_state;
   logic        halted;

   modport master (
      output instruction, pc, ram, ir, acc, b,
      input  control_word, w_bus, alu_result, t_state, halted
   );

   modport slave (
      input  instruction, pc, ram, ir, acc, b,
      output control_word, w_bus, alu_result, t_state, halted
   );

endinterface

// File: rtl/sap_ring_controller.sv
// rtl/sap_ring_controller.sv - SAP-1 six-state ring counter, halt flag and control-word decode
// Ports:
//   clock           rising-edge clock
//   reset           synchronous active-high reset, forces T1 and clears halt
//   instruction_i   opcode IR[7:4], decoded in T4..T6
//   t_state_o       one-hot ring state, all-zero while halted
//   control_word_o  combinational control word from state and opcode
//   halted_o        high while in the halted state
module sap_ring_controller
   import sap_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  instruction_i,
   output t_state_e    t_state_o,
   output logic [11:0] control_word_o,
   output logic        halted_o
);

   t_state_e state_q;
   t_state_e state_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= T1;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      control_word_o = CW_WORD_NOP;
      case (state_q)
         T1: begin
            control_word_o = CW_WORD_FETCH_T1;
            state_d        = T2;
         end
         T2: begin
            control_word_o = CW_WORD_FETCH_T2;
            state_d        = T3;
         end
         T3: begin
            control_word_o = CW_WORD_FETCH_T3;
            state_d        = T4;
         end
         T4: begin
            state_d = T5;
            case (instruction_i)
               OP_LDA, OP_ADD, OP_SUB: control_word_o = CW_WORD_ADDR_T4;
               OP_OUT:                 control_word_o = CW_WORD_OUT_T4;
               OP_HLT:                 state_d        = T_HALT;
               default:                control_word_o = CW_WORD_NOP;
            endcase
         end
         T5: begin
            state_d = T6;
            case (instruction_i)
               OP_LDA:         control_word_o = CW_WORD_LDA_T5;
               OP_ADD, OP_SUB: control_word_o = CW_WORD_ARITH_T5;
               default:        control_word_o = CW_WORD_NOP;
            endcase
         end
         T6: begin
            state_d = T1;
            case (instruction_i)
               OP_ADD:  control_word_o = CW_WORD_ADD_T6;
               OP_SUB:  control_word_o = CW_WORD_SUB_T6;
               default: control_word_o = CW_WORD_NOP;
            endcase
         end
         T_HALT: begin
            // Only reset leaves the halted state.
            state_d = T_HALT;
         end
         default: begin
            // Non one-hot encodings cannot be reached normally; restart the fetch.
            state_d = T1;
         end
      endcase
   end

   assign t_state_o = state_q;
   assign halted_o  = (state_q == T_HALT);

endmodule

// File: rtl/sap_control_datapath.sv
// rtl/sap_control_datapath.sv - SAP-1 controller with inline ALU and W-bus multiplexer
// Ports:
//   clock   rising-edge clock
//   reset   synchronous active-high reset
//   bus     slave side of sap_control_datapath_if: opcode, pc, ram, ir, acc, b in;
//           control_word, w_bus, alu_result, t_state, halted out
module sap_control_datapath
   import sap_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset,
   sap_control_datapath_if.slave  bus
);

   t_state_e    t_state;
   logic [11:0] cw;
   logic        halted;
   logic [7:0]  alu_result;
   logic [7:0]  w_bus;

   sap_ring_controller u_ring (
      .clock          (clock),
      .reset          (reset),
      .instruction_i  (bus.instruction),
      .t_state_o      (t_state),
      .control_word_o (cw),
      .halted_o       (halted)
   );

   // The ALU always computes; Eu only decides whether it drives the bus.
   assign alu_result = cw[CW_SU] ? (bus.acc - bus.b) : (bus.acc + bus.b);

   // Encodings enable at most one source; the priority only matters for illegal words.
   always_comb begin
      w_bus = 8'h00;
      if (cw[CW_EP]) begin
         w_bus = {4'h0, bus.pc};
      end else if (!cw[CW_CE_N]) begin
         w_bus = bus.ram;
      end else if (!cw[CW_EI_N]) begin
         w_bus = {4'h0, bus.ir};
      end else if (cw[CW_EA]) begin
         w_bus = bus.acc;
      end else if (cw[CW_EU]) begin
         w_bus = alu_result;
      end
   end

   assign bus.control_word = cw;
   assign bus.w_bus        = w_bus;
   assign bus.alu_result   = alu_result;
   assign bus.t_state      = t_state;
   assign bus.halted       = halted;

endmodule

// File: tb/tb_sap_control_datapath.sv
// tb/tb_sap_control_datapath.sv - self-checking bench for sap_control_datapath
module tb_sap_control_datapath;

   logic clock;
   logic reset;
   int   vectors;
   int   miscompares;

   // Reference model: instruction step 0..5 (T1..T6) and halt flag.
   int   m_step;
   bit   m_hlt;

   sap_control_datapath_if bus_if ();

   sap_control_datapath dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [11:0] exp_cw(input int step, input bit hlt, input logic [3:0] op);
      if (hlt) return 12'h3E3;
      case (step)
         0: return 12'h5E3;
         1: return 12'hBE3;
         2: return 12'h263;
         3: if (op == 4'h0 || op == 4'h1 || op == 4'h2) return 12'h1A3;
            else if (op == 4'hE) return 12'h3F2;
            else return 12'h3E3;
         4: if (op == 4'h0) return 12'h2C3;
            else if (op == 4'h1 || op == 4'h2) return 12'h2E1;
            else return 12'h3E3;
         default: if (op == 4'h1) return 12'h3C7;
            else if (op == 4'h2) return 12'h3CF;
            else return 12'h3E3;
      endcase
   endfunction

   // Sum or difference modulo 256: only SUB in its last step subtracts.
   function automatic logic [7:0] exp_alu(input int step, input bit hlt, input logic [3:0] op,
                                          input logic [7:0] a, input logic [7:0] bb);
      if (!hlt && step == 5 && op == 4'h2) return 8'((int'(a) - int'(bb) + 256) % 256);
      return 8'((int'(a) + int'(bb)) % 256);
   endfunction

   // What each instruction step puts on the bus, in instruction terms.
   function automatic logic [7:0] exp_bus(input int step, input bit hlt, input logic [3:0] op,
                                          input logic [3:0] pc, input logic [7:0] ram,
                                          input logic [3:0] ir, input logic [7:0] a,
                                          input logic [7:0] bb);
      bit mem_op;
      mem_op = (op == 4'h0 || op == 4'h1 || op == 4'h2);
      if (hlt) return 8'h00;
      case (step)
         0: return {4'h0, pc};
         2: return ram;
         3: if (mem_op) return {4'h0, ir};
            else if (op == 4'hE) return a;
            else return 8'h00;
         4: return mem_op ? ram : 8'h00;
         5: return (op == 4'h1 || op == 4'h2) ? exp_alu(step, hlt, op, a, bb) : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [11:0] cw_e;
      logic [5:0]  ts_e;
      cw_e = exp_cw(m_step, m_hlt, bus_if.instruction);
      ts_e = m_hlt ? 6'b000000 : 6'(1 << m_step);
      chk({tag, ".cw"}, bus_if.control_word, cw_e);
      chk({tag, ".ts"}, 12'(bus_if.t_state), 12'(ts_e));
      chk({tag, ".halted"}, 12'(bus_if.halted), 12'(m_hlt));
      chk({tag, ".alu"}, 12'(bus_if.alu_result),
          12'(exp_alu(m_step, m_hlt, bus_if.instruction, bus_if.acc, bus_if.b)));
      chk({tag, ".wbus"}, 12'(bus_if.w_bus),
          12'(exp_bus(m_step, m_hlt, bus_if.instruction, bus_if.pc, bus_if.ram,
                      bus_if.ir, bus_if.acc, bus_if.b)));
   endtask

   task automatic clk_edge();
      @(posedge clock);
      if (reset) begin
         m_step = 0;
         m_hlt  = 1'b0;
      end else if (!m_hlt) begin
         if (m_step == 3 && bus_if.instruction == 4'hF) m_hlt = 1'b1;
         else m_step = (m_step + 1) % 6;
      end
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [3:0] pc, input logic [7:0] ram,
                        input logic [3:0] ir, input logic [7:0] a, input logic [7:0] bb);
      bus_if.instruction = op;
      bus_if.pc          = pc;
      bus_if.ram         = ram;
      bus_if.ir          = ir;
      bus_if.acc         = a;
      bus_if.b           = bb;
   endtask

   task automatic cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         clk_edge();
         check_all(tag);
      end
   endtask

   initial begin
      int halt_len;
      vectors     = 0;
      miscompares = 0;
      m_step      = 0;
      m_hlt       = 1'b0;

      // Reset and fetch
      reset = 1'b1;
      drive(4'h1, 4'hA, 8'h11, 4'h3, 8'h05, 8'h03);
      clk_edge();
      reset = 1'b0;
      #1;
      check_all("rst");
      chk("rst_cw", bus_if.control_word, 12'h5E3);
      chk("rst_ts", 12'(bus_if.t_state), 12'h001);
      chk("rst_halted", 12'(bus_if.halted), 12'h000);
      chk("t1_pc_bus", 12'(bus_if.w_bus), 12'h00A);
      cycles(1, "t2");
      chk("t2_cw", bus_if.control_word, 12'hBE3);
      chk("t2_ts", 12'(bus_if.t_state), 12'h002);
      cycles(1, "t3");
      chk("t3_cw", bus_if.control_word, 12'h263);
      chk("t3_ts", 12'(bus_if.t_state), 12'h004);

      // ADD 5 + 3, then 0xFF + 0x02 wraps
      cycles(1, "add_t4");
      chk("add_t4_cw", bus_if.control_word, 12'h1A3);
      cycles(1, "add_t5");
      chk("add_t5_cw", bus_if.control_word, 12'h2E1);
      cycles(1, "add_t6");
      chk("add_t6_cw", bus_if.control_word, 12'h3C7);
      chk("add_t6_bus", 12'(bus_if.w_bus), 12'h008);
      drive(4'h1, 4'hA, 8'h11, 4'h3, 8'hFF, 8'h02);
      #1;
      check_all("add_wrap");
      chk("add_wrap_bus", 12'(bus_if.w_bus), 12'h001);

      // SUB 3 - 5
      drive(4'h2, 4'h4, 8'h22, 4'h9, 8'h03, 8'h05);
      cycles(6, "sub");
      chk("sub_t6_cw", bus_if.control_word, 12'h3CF);
      chk("sub_t6_bus", 12'(bus_if.w_bus), 12'h0FE);

      // LDA bus sources
      drive(4'h0, 4'h5, 8'h33, 4'h7, 8'h44, 8'h01);
      cycles(4, "lda");
      chk("lda_t4_bus", 12'(bus_if.w_bus), 12'h007);
      cycles(1, "lda_t5");
      chk("lda_t5_cw", bus_if.control_word, 12'h2C3);
      cycles(1, "lda_t6");
      chk("lda_t6_bus", 12'(bus_if.w_bus), 12'h000);

      // OUT
      drive(4'hE, 4'h6, 8'h55, 4'h1, 8'h5C, 8'h10);
      cycles(4, "out");
      chk("out_t4_cw", bus_if.control_word, 12'h3F2);
      chk("out_t4_bus", 12'(bus_if.w_bus), 12'h05C);
      cycles(2, "out_tail");

      // Undefined opcode keeps cycling
      drive(4'h7, 4'h2, 8'h66, 4'h2, 8'h12, 8'h34);
      cycles(7, "undef");
      chk("undef_ts", 12'(bus_if.t_state), 12'h001);

      // Reset in the middle of ADD T5
      drive(4'h1, 4'h3, 8'h77, 4'h4, 8'h20, 8'h30);
      cycles(4, "add_mid");
      reset = 1'b1;
      clk_edge();
      reset = 1'b0;
      #1;
      check_all("mid_rst");
      chk("mid_rst_cw", bus_if.control_word, 12'h5E3);
      chk("mid_rst_ts", 12'(bus_if.t_state), 12'h001);
      cycles(6, "after_mid_rst");

      // HLT at T4
      drive(4'hF, 4'h8, 8'h88, 4'h8, 8'h01, 8'h02);
      cycles(3, "hlt_fetch");
      chk("hlt_t4_cw", bus_if.control_word, 12'h3E3);
      clk_edge();
      for (int i = 0; i < 10; i++) begin
         drive(4'($urandom_range(0, 15)), 4'($urandom), 8'($urandom), 4'($urandom),
               8'($urandom), 8'($urandom));
         #1;
         check_all("halted");
         chk("halted_flag", 12'(bus_if.halted), 12'h001);
         chk("halted_cw", bus_if.control_word, 12'h3E3);
         clk_edge();
      end
      reset = 1'b1;
      clk_edge();
      reset = 1'b0;
      #1;
      chk("hlt_rst_cw", bus_if.control_word, 12'h5E3);
      chk("hlt_rst_halted", 12'(bus_if.halted), 12'h000);

      // Randomized run against the model
      halt_len = 0;
      for (int i = 0; i < 600; i++) begin
         drive(4'($urandom_range(0, 15)), 4'($urandom), 8'($urandom), 4'($urandom),
               8'($urandom), 8'($urandom));
         reset = ($urandom_range(0, 49) == 0) || (halt_len > 3);
         #1;
         check_all("rand");
         clk_edge();
         halt_len = m_hlt ? halt_len + 1 : 0;
         reset = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
